apb_regfile_slave: RTL and testbench
====================================

// Module: apb_regfile_slave
// PURPOSE
// - Parametrised APB register-file slave behind the AHB-APB bridge; replaces the stub slave that echoed
//   APB signals and returned random read data.
// - Decodes one bit of Pselx and holds NUM_REGS writable registers, with register 0 a read-only ID.
// - Adds programmable wait states (Pready), error response (Pslverr), byte strobes and a register
//   output bus for downstream peripherals (GPIO, UART control).
// PARAMETERS
// DATA_WIDTH   32            data bus width; multiple of 8
// ADDR_WIDTH   32            Paddr width
// NUM_REGS     8             number of word registers, >=2; index 0 is the ID register
// SEL_INDEX    0             bit of Pselx that selects this slave (0..2)
// WAIT_STATES  1             access-phase cycles with Pready low before completion (0..15)
// ID_VALUE     32'hA9B0_0001 constant returned by register 0
// PORTS
// Hclk     in   1                    bridge clock, rising edge
// Hresetn  in   1                    asynchronous active-low reset
// Pselx    in   3                    one-hot slave selects from bridge
// Penable  in   1                    APB access phase
// Pwrite   in   1                    1 = write, 0 = read
// Paddr    in   ADDR_WIDTH           byte address
// Pwdata   in   DATA_WIDTH           write data
// Pstrb    in   DATA_WIDTH/8         byte write enables
// Prdata   out  DATA_WIDTH           read data
// Pready   out  1                    transfer completes this cycle
// Pslverr  out  1                    error response, valid only with Pready
// reg_q    out  NUM_REGS*DATA_WIDTH  register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
// - sel = Pselx[SEL_INDEX]; idx = Paddr[ADDR_WIDTH-1:2]; Paddr[1:0] ignored.
// - Reset (async on Hresetn low): state IDLE, wait counter 0, regs 1..N-1 = 0, Prdata = 0,
//   Pready = 0, Pslverr = 0. Reset during a transfer aborts it; nothing is committed.
// - FSM IDLE: on sel & ~Penable (setup phase), latch idx/Pwrite/Pwdata/Pstrb, load cnt = WAIT_STATES,
//   go to ACCESS. Otherwise stay in IDLE.
// - FSM ACCESS: requires sel & Penable. If cnt != 0: Pready = 0, cnt decrements.
//   If cnt == 0: Pready = 1 (combinational from state/cnt), return to IDLE on the next edge.
// - Abort: in ACCESS, sel or Penable low -> return to IDLE, no commit, Pready stays 0.
// - Latency: setup + WAIT_STATES + 1 completion cycle = WAIT_STATES+2 cycles per transfer.
//   Back-to-back transfers are allowed because IDLE samples the next setup phase immediately.
// - Error: idx >= NUM_REGS, or write to idx 0 -> Pslverr = 1 in the completion cycle,
//   write dropped, Prdata = 0.
// - Write commit: at the completion edge, for each byte b with Pstrb[b]=1, reg[idx][8b+7:8b] <= Pwdata byte.
//   Pstrb = 0 commits nothing and returns OKAY.
// - Read: Prdata = reg[idx] (ID_VALUE for idx 0) only in the completion cycle of a non-error read;
//   Prdata = 0 in every other cycle.
// - Pslverr and Prdata are 0 whenever Pready = 0.
// - ID_VALUE is truncated or zero-extended to DATA_WIDTH.
// - reg_q updates the cycle after the write commit edge; reg_q[0 +: DATA_WIDTH] = ID_VALUE constant.
// STRUCTURE
// - Shared package apb_pkg: FSM state encoding (ST_IDLE, ST_ACCESS), APB response constants
//   (RESP_OKAY, RESP_ERR), default ID value.
// - Sub-module apb_wait_ctr: loadable down-counter (load, value, zero flag) sized to hold WAIT_STATES.
// - Decode, byte-strobe write and read mux stay in this module.
// TESTING
// - Reset: Hresetn low 3 cycles -> Prdata=0, Pready=0, Pslverr=0, reg_q[1..7]=0.
// - Write idx2 Pwdata=32'hDEAD_BEEF, Pstrb=4'hF, WAIT_STATES=1 -> Pready high in cycle 3, reg2 reads
//   32'hDEAD_BEEF, Pslverr=0.
// - Byte strobe: reg2=32'hDEAD_BEEF, write 32'h1122_3344 with Pstrb=4'b0101 -> reg2=32'hDE22_BE44.
// - Read idx0 -> Prdata=32'hA9B0_0001; write idx0 -> Pslverr=1 and the value is unchanged.
//   Read Paddr=32'h40 (idx16, NUM_REGS=8) -> Pslverr=1, Prdata=0.
// - Abort and wait states: drop Penable mid-wait with WAIT_STATES=3 -> no commit, back to IDLE.
//   WAIT_STATES=0 -> Pready in the 2nd cycle; back-to-back write then read -> 2 cycles each.
// - Reset mid-access (Hresetn low while cnt=2) -> no commit, all outputs 0; Pselx[1] only with
//   SEL_INDEX=0 -> never Pready.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, response codes, default ID and
// counter sizing helper.
package apb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  localparam logic [31:0] DEFAULT_ID = 32'hA9B0_0001;

  // Bits needed to hold max_value; never less than one.
  function automatic int cnt_width(input int max_value);
    if (max_value < 2) return 1;
    return $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that paces APB wait states; zero flags completion.
module apb_wait_ctr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= value;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/apb_regfile_slave.sv
// APB register-file slave: read-only ID at index 0, byte-strobed writable
// registers above it, programmable wait states and error response.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          SEL_INDEX   = 0,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
  input  logic                           Hclk,
  input  logic                           Hresetn,
  input  logic [2:0]                     Pselx,
  input  logic                           Penable,
  input  logic                           Pwrite,
  input  logic [ADDR_WIDTH-1:0]          Paddr,
  input  logic [DATA_WIDTH-1:0]          Pwdata,
  input  logic [DATA_WIDTH/8-1:0]        Pstrb,
  output logic [DATA_WIDTH-1:0]          Prdata,
  output logic                           Pready,
  output logic                           Pslverr,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int CNT_W  = cnt_width(WAIT_STATES);
  localparam logic [DATA_WIDTH-1:0] ID_WORD = DATA_WIDTH'(ID_VALUE);

  apb_state_e          state_reg, state_next;
  logic                sel, setup, access_ok, cnt_zero;
  logic [IDX_W-1:0]    idx_reg;
  logic                write_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_W-1:0]   strb_reg;
  logic                err, pready_int, commit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                unused_bits;

  assign sel       = Pselx[SEL_INDEX];
  assign setup     = (state_reg == ST_IDLE) && sel && !Penable;
  assign access_ok = sel && Penable;
  assign unused_bits = ^{Paddr[1:0], Pselx};

  apb_wait_ctr #(.WIDTH(CNT_W)) u_wait_ctr (
    .clk   (Hclk),
    .rst_n (Hresetn),
    .load  (setup),
    .dec   ((state_reg == ST_ACCESS) && access_ok),
    .value (CNT_W'(WAIT_STATES)),
    .zero  (cnt_zero)
  );

  // Setup-phase capture; the access phase works only from these copies.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      idx_reg   <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
    end else if (setup) begin
      idx_reg   <= Paddr[ADDR_WIDTH-1:2];
      write_reg <= Pwrite;
      wdata_reg <= Pwdata;
      strb_reg  <= Pstrb;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (setup) state_next = ST_ACCESS;
      ST_ACCESS: if (!access_ok || cnt_zero) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign err    = (idx_reg >= IDX_W'(NUM_REGS)) || (write_reg && (idx_reg == '0));
  assign commit = pready_int && write_reg && !err;

  always_comb begin
    rd_word = ID_WORD;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx_reg == IDX_W'(i)) rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Response outputs are all forced to zero outside the completion cycle.
  always_comb begin
    pready_int = (state_reg == ST_ACCESS) && access_ok && cnt_zero;
    Pready     = pready_int;
    Pslverr    = RESP_OKAY;
    Prdata     = '0;
    if (pready_int) begin
      Pslverr = err ? RESP_ERR : RESP_OKAY;
      if (!write_reg && !err) Prdata = rd_word;
    end
  end

  assign reg_q[0 +: DATA_WIDTH] = ID_WORD;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATA_WIDTH-1:0] word_reg;

    always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
        word_reg <= '0;
      end else if (commit && (idx_reg == IDX_W'(gi))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (strb_reg[b]) word_reg[8*b +: 8] <= wdata_reg[8*b +: 8];
        end
      end
    end

    assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench: three slaves with 1, 3 and 0 wait states driven by
// directed APB transfers; a negedge monitor checks every completion.
module tb_apb_regfile_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   pselx   [3];
  logic         penable [3];
  logic         pwrite  [3];
  logic [31:0]  paddr   [3];
  logic [31:0]  pwdata  [3];
  logic [3:0]   pstrb   [3];
  logic [31:0]  prdata  [3];
  logic         pready  [3];
  logic         pslverr [3];
  logic [255:0] reg_q   [3];

  int cyc = 0;
  int nchecks = 0;
  int errors = 0;
  int ws_of [3] = '{1, 3, 0};

  typedef struct {
    int          dut;
    int          cyc;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  localparam logic [255:0] RQ_RESET = {224'h0, 32'hA9B0_0001};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_regfile_slave #(.WAIT_STATES(1)) u_ws1 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(pselx[0]), .Penable(penable[0]),
    .Pwrite(pwrite[0]), .Paddr(paddr[0]), .Pwdata(pwdata[0]), .Pstrb(pstrb[0]),
    .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]), .reg_q(reg_q[0])
  );
  apb_regfile_slave #(.WAIT_STATES(3)) u_ws3 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(pselx[1]), .Penable(penable[1]),
    .Pwrite(pwrite[1]), .Paddr(paddr[1]), .Pwdata(pwdata[1]), .Pstrb(pstrb[1]),
    .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]), .reg_q(reg_q[1])
  );
  apb_regfile_slave #(.WAIT_STATES(0)) u_ws0 (
    .Hclk(clk), .Hresetn(rst_n), .Pselx(pselx[2]), .Penable(penable[2]),
    .Pwrite(pwrite[2]), .Paddr(paddr[2]), .Pwdata(pwdata[2]), .Pstrb(pstrb[2]),
    .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]), .reg_q(reg_q[2])
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchecks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int d, input int i);
    logic [255:0] v;
    v = reg_q[d];
    return v[i*32 +: 32];
  endfunction

  task automatic drive(input int d, input logic [2:0] sel, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    pselx[d]   = sel;
    penable[d] = en;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    pstrb[d]   = strb;
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < 3; d++) drive(d, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; the current cycle is the setup phase.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic exp_err, input logic [31:0] exp_rd);
    exp_t e;
    e.dut   = d;
    e.cyc   = cyc + 1 + ws_of[d];
    e.err   = exp_err;
    e.rdata = exp_rd;
    sb.push_back(e);
    drive(d, 3'b001, 1'b0, wr, addr, wdata, strb);
    @(posedge clk);
    #1 penable[d] = 1'b1;
    repeat (ws_of[d] + 1) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (pready[d]) begin
          if (sb.size() == 0) begin
            nchecks++;
            errors++;
            $display("FAIL unexpected_pready: dut %0d cycle %0d got pready=1 expected 0", d, cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_dut", 256'(d), 256'(e.dut));
            chk("sb_cycle", 256'(cyc), 256'(e.cyc));
            chk("sb_pslverr", 256'(pslverr[d]), 256'(e.err));
            chk("sb_prdata", 256'(prdata[d]), 256'(e.rdata));
            $display("txn dut=%0d cyc=%0d pslverr=%0b prdata=%h", d, cyc, pslverr[d], prdata[d]);
          end
        end else begin
          chk("idle_pslverr", 256'(pslverr[d]), '0);
          chk("idle_prdata", 256'(prdata[d]), '0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_pready", 256'(pready[d]), '0);
      chk("rst_prdata", 256'(prdata[d]), '0);
      chk("rst_pslverr", 256'(pslverr[d]), '0);
      chk("rst_reg_q", reg_q[d], RQ_RESET);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // One wait state: data path, strobes, ID and decode errors.
    xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    chk("reg_q_word2", 256'(word(0, 2)), 256'(32'hDEAD_BEEF));
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
    xfer(0, 1'b1, 32'h8, 32'h1122_3344, 4'b0101, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hA9B0_0001);
    xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hA9B0_0001);
    xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h0);
    xfer(0, 1'b1, 32'h40, 32'h5555_5555, 4'hF, 1'b1, 32'h0);
    xfer(0, 1'b1, 32'h8, 32'h0BAD_0BAD, 4'h0, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44);
    xfer(0, 1'b1, 32'h1F, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, 1'b0, 32'h1234_5678);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h0);
    idle(2);

    // Zero wait states, back to back.
    xfer(2, 1'b1, 32'h4, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0);
    xfer(2, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D);
    xfer(2, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hA9B0_0001);
    idle(2);

    // Three wait states, then an access aborted by dropping Penable.
    xfer(1, 1'b1, 32'hC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0);
    drive(1, 3'b001, 1'b0, 1'b1, 32'hC, 32'h0F0F_0F0F, 4'hF);
    @(posedge clk);
    #1 penable[1] = 1'b1;
    @(posedge clk);
    #1 penable[1] = 1'b0;
    @(negedge clk);
    chk("abort_pready", 256'(pready[1]), '0);
    idle(3);
    chk("abort_no_commit", 256'(word(1, 3)), 256'(32'hA5A5_A5A5));
    xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0, 32'hA5A5_A5A5);
    idle(1);

    // Select line belonging to another slave.
    drive(0, 3'b010, 1'b0, 1'b1, 32'h8, 32'h0, 4'hF);
    @(negedge clk);
    chk("foreign_sel_pready", 256'(pready[0]), '0);
    @(posedge clk);
    #1 penable[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("foreign_sel_pready", 256'(pready[0]), '0);
    end
    idle(2);
    chk("foreign_sel_no_write", 256'(word(0, 2)), 256'(32'hDE22_BE44));

    // Reset asserted while the counter holds 2.
    drive(1, 3'b001, 1'b0, 1'b1, 32'h10, 32'h7777_7777, 4'hF);
    @(posedge clk);
    #1 penable[1] = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_pready", 256'(pready[1]), '0);
    chk("midrst_prdata", 256'(prdata[1]), '0);
    chk("midrst_pslverr", 256'(pslverr[1]), '0);
    chk("midrst_reg_q1", reg_q[1], RQ_RESET);
    chk("midrst_reg_q0", reg_q[0], RQ_RESET);
    for (int d = 0; d < 3; d++) drive(d, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0);
    xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, 32'h0);
    idle(3);

    chk("sb_drain", 256'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
